// File: rtl/lms_pkg.sv
// Shared types and helpers for the LMS coefficient-update engine.
package lms_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } lms_state_t;

    localparam int NTAPS_DEFAULT = 16;
    localparam int IDXW          = $clog2(NTAPS_DEFAULT);

    // Clamp a sign-extended value to the signed range of a ww-bit word.
    function automatic logic signed [63:0] sat_to_width(
        input logic signed [63:0] v,
        input int                 ww
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (ww - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (ww - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/lms_tap_update.sv
// Combinational single-tap LMS update: multiply, step shift, leak, add, saturate.
module lms_tap_update
    import lms_pkg::*;
#(
    parameter int DW         = 14,
    parameter int WW         = 32,
    parameter int LEAK_SHIFT = 12
) (
    input  logic signed [DW-1:0] i_e,
    input  logic signed [DW-1:0] i_x,
    input  logic        [4:0]    i_mu,
    input  logic                 i_leak_en,
    input  logic signed [WW-1:0] i_w,
    output logic signed [WW-1:0] o_w,
    output logic                 o_sat
);

    logic signed [2*DW-1:0] w_prod;
    logic signed [2*DW-1:0] w_shifted;
    logic signed [WW:0]     w_delta;
    logic signed [WW-1:0]   w_leak;
    logic signed [WW:0]     w_sum;
    logic signed [63:0]     w_sum64;
    logic signed [63:0]     w_sat64;

    assign w_prod    = i_e * i_x;
    assign w_shifted = w_prod >>> i_mu;
    assign w_delta   = {{(WW+1-2*DW){w_shifted[2*DW-1]}}, w_shifted};
    assign w_leak    = i_leak_en ? (i_w >>> LEAK_SHIFT) : '0;

    // One guard bit keeps the sum exact before clamping.
    assign w_sum   = {i_w[WW-1], i_w} - {w_leak[WW-1], w_leak} + w_delta;
    assign w_sum64 = {{(63-WW){w_sum[WW]}}, w_sum};
    assign w_sat64 = sat_to_width(w_sum64, WW);

    assign o_w   = w_sat64[WW-1:0];
    assign o_sat = (w_sat64 != w_sum64);

endmodule

// File: rtl/lms_weight_engine.sv
// Time-multiplexed LMS weight engine: one shared update datapath, one tap per cycle.
module lms_weight_engine
    import lms_pkg::*;
#(
    parameter int NTAPS      = NTAPS_DEFAULT,
    parameter int DW         = 14,
    parameter int WW         = 32,
    parameter int LEAK_SHIFT = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic signed [DW-1:0]       e,
    input  logic        [4:0]          mu_shift,
    input  logic                       leak_en,
    input  logic                       clear,
    output logic [$clog2(NTAPS)-1:0]   ref_idx,
    input  logic signed [DW-1:0]       ref_data,
    output logic                       busy,
    output logic                       done,
    output logic                       sat_flag,
    output logic [NTAPS*WW-1:0]        w_flat,
    output lms_state_t                 dbg_state
);

    localparam int            IW   = $clog2(NTAPS);
    localparam logic [IW-1:0] LAST = IW'(NTAPS - 1);

    lms_state_t           r_state;
    lms_state_t           w_state_nxt;
    logic [IW-1:0]        r_idx;
    logic signed [DW-1:0] r_e;
    logic [4:0]           r_mu;
    logic                 r_leak;
    logic                 r_sat;
    logic signed [WW-1:0] r_w [NTAPS];
    logic signed [WW-1:0] w_upd;
    logic                 w_clip;
    logic                 w_accept;

    assign w_accept = (r_state == ST_IDLE) && start && !clear;

    lms_tap_update #(
        .DW         (DW),
        .WW         (WW),
        .LEAK_SHIFT (LEAK_SHIFT)
    ) u_tap_update (
        .i_e       (r_e),
        .i_x       (ref_data),
        .i_mu      (r_mu),
        .i_leak_en (r_leak),
        .i_w       (r_w[r_idx]),
        .o_w       (w_upd),
        .o_sat     (w_clip)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (clear) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_idx == LAST) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx  <= '0;
            r_e    <= '0;
            r_mu   <= '0;
            r_leak <= 1'b0;
        end else if (w_accept) begin
            r_idx  <= '0;
            r_e    <= e;
            r_mu   <= mu_shift;
            r_leak <= leak_en;
        end else if (r_state == ST_RUN) begin
            r_idx <= (clear || r_idx == LAST) ? '0 : r_idx + IW'(1);
        end
    end

    // Clear wins over an in-flight write, so an aborted sweep leaves nothing behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NTAPS; k++) r_w[k] <= '0;
            r_sat <= 1'b0;
        end else if (clear) begin
            for (int k = 0; k < NTAPS; k++) r_w[k] <= '0;
            r_sat <= 1'b0;
        end else if (r_state == ST_RUN) begin
            r_w[r_idx] <= w_upd;
            if (w_clip) r_sat <= 1'b1;
        end
    end

    for (genvar g = 0; g < NTAPS; g++) begin : g_flat
        assign w_flat[g*WW +: WW] = r_w[g];
    end

    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);
    assign ref_idx   = (r_state == ST_RUN) ? r_idx : '0;
    assign sat_flag  = r_sat;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_lms_weight_engine.sv
// Directed bench for lms_weight_engine with hand-computed expected weights.
module tb_lms_weight_engine;
    import lms_pkg::*;

    localparam int NT = 16;
    localparam int DW = 14;
    localparam int WW = 32;
    localparam int FW = NT * WW;

    logic                 clk      = 1'b0;
    logic                 rst      = 1'b1;
    logic                 start    = 1'b0;
    logic                 leak_en  = 1'b0;
    logic                 clear    = 1'b0;
    logic signed [DW-1:0] e        = '0;
    logic [4:0]           mu_shift = '0;
    logic [3:0]           ref_idx;
    logic signed [DW-1:0] ref_data;
    logic                 busy;
    logic                 done;
    logic                 sat_flag;
    logic [FW-1:0]        w_flat;
    lms_state_t           dbg_state;

    logic signed [DW-1:0] x_mem [NT];
    int checks = 0;
    int errors = 0;
    int bc, dp, da;

    always #5 clk = ~clk;

    assign ref_data = x_mem[ref_idx];

    lms_weight_engine #(
        .NTAPS(NT), .DW(DW), .WW(WW), .LEAK_SHIFT(12)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .e         (e),
        .mu_shift  (mu_shift),
        .leak_en   (leak_en),
        .clear     (clear),
        .ref_idx   (ref_idx),
        .ref_data  (ref_data),
        .busy      (busy),
        .done      (done),
        .sat_flag  (sat_flag),
        .w_flat    (w_flat),
        .dbg_state (dbg_state)
    );

    task automatic chk_i(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_v(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input int k, input int exp);
        logic signed [WW-1:0] o;
        o = w_flat[k*WW +: WW];
        checks++;
        assert (o === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, exp);
        end
    endtask

    task automatic set_x_all(input int v);
        for (int k = 0; k < NT; k++) x_mem[k] = DW'(v);
    endtask

    task automatic set_x0_only(input int v);
        for (int k = 0; k < NT; k++) x_mem[k] = '0;
        x_mem[0] = DW'(v);
    endtask

    task automatic clear_pulse();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    // Launch a sweep, optionally re-pulse start at loop cycle 'poke', and
    // report busy cycles, done pulses and the cycle index done was seen at.
    task automatic run_sweep(input int ev, input int mu, input logic lk, input int poke,
                             output int o_bc, output int o_dp, output int o_da);
        @(negedge clk);
        e        = DW'(ev);
        mu_shift = 5'(mu);
        leak_en  = lk;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        o_bc = 0;
        o_dp = 0;
        o_da = -1;
        for (int c = 0; c < 40; c++) begin
            if (!busy) break;
            o_bc++;
            if (done) begin
                o_dp++;
                o_da = c;
            end
            if (c == poke) begin
                start = 1'b1;
                e     = 14'sd555;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic start_and_wait_idx(input int ev, input int target, output int found);
        @(negedge clk);
        e        = DW'(ev);
        mu_shift = 5'd4;
        leak_en  = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int c = 0; c < 30; c++) begin
            if (ref_idx == 4'(target) && busy) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int found;
        int dcount;
        set_x_all(0);

        // Reset values
        @(negedge clk);
        @(negedge clk);
        chk_i("rst_busy", int'(busy), 0);
        chk_i("rst_done", int'(done), 0);
        chk_i("rst_sat", int'(sat_flag), 0);
        chk_i("rst_ref_idx", int'(ref_idx), 0);
        chk_i("rst_state", int'(dbg_state), int'(ST_IDLE));
        chk_v("rst_w", w_flat, '0);
        rst = 1'b0;

        // Basic sweep: 100*64 >>> 4 = 400 on every tap
        set_x_all(64);
        run_sweep(100, 4, 1'b0, -1, bc, dp, da);
        chk_i("sweep1_busy_cycles", bc, 17);
        chk_i("sweep1_done_pulses", dp, 1);
        chk_i("sweep1_done_at", da, 16);
        chk_v("sweep1_w", w_flat, {NT{32'd400}});

        // Asynchronous reset in the middle of a sweep
        start_and_wait_idx(100, 7, found);
        chk_i("rst_mid_reached_idx7", found, 1);
        rst = 1'b1;
        #1;
        chk_i("rst_mid_busy", int'(busy), 0);
        chk_i("rst_mid_done", int'(done), 0);
        chk_i("rst_mid_ref_idx", int'(ref_idx), 0);
        chk_i("rst_mid_state", int'(dbg_state), int'(ST_IDLE));
        chk_v("rst_mid_w", w_flat, '0);
        @(negedge clk);
        rst = 1'b0;

        // Positive then negative error cancel out
        run_sweep(100, 4, 1'b0, -1, bc, dp, da);
        chk_v("pos_w", w_flat, {NT{32'd400}});
        run_sweep(-100, 4, 1'b0, -1, bc, dp, da);
        chk_i("neg_busy_cycles", bc, 17);
        chk_i("neg_done_pulses", dp, 1);
        chk_v("neg_w", w_flat, '0);

        // Arithmetic shift rounds toward minus infinity
        set_x0_only(1);
        run_sweep(-3, 1, 1'b0, -1, bc, dp, da);
        chk_w("round_neg_w0", 0, -2);
        chk_w("round_neg_w1", 1, 0);
        run_sweep(3, 1, 1'b0, -1, bc, dp, da);
        chk_w("round_pos_w0", 0, -1);

        // Saturation: 8191*8191 = 67092481 per sweep
        clear_pulse();
        set_x0_only(8191);
        for (int s = 0; s < 32; s++) run_sweep(8191, 0, 1'b0, -1, bc, dp, da);
        chk_w("sat32_w0", 0, 2146959392);
        chk_i("sat32_flag", int'(sat_flag), 0);
        run_sweep(8191, 0, 1'b0, -1, bc, dp, da);
        chk_w("sat33_w0", 0, 2147483647);
        chk_i("sat33_flag", int'(sat_flag), 1);
        run_sweep(8191, 0, 1'b0, -1, bc, dp, da);
        chk_w("sat34_w0", 0, 2147483647);
        chk_i("sat34_flag", int'(sat_flag), 1);

        // Leakage: 40960 - (40960 >>> 12) = 40950
        clear_pulse();
        chk_i("clear_sat", int'(sat_flag), 0);
        set_x0_only(8);
        run_sweep(5120, 0, 1'b0, -1, bc, dp, da);
        chk_w("leak_preset_w0", 0, 40960);
        run_sweep(0, 0, 1'b0, -1, bc, dp, da);
        chk_w("leak_off_w0", 0, 40960);
        run_sweep(0, 0, 1'b1, -1, bc, dp, da);
        chk_w("leak_on_w0", 0, 40950);

        // Start while busy is ignored
        clear_pulse();
        set_x_all(64);
        run_sweep(100, 4, 1'b0, 3, bc, dp, da);
        chk_i("poke_busy_cycles", bc, 17);
        chk_i("poke_done_pulses", dp, 1);
        chk_v("poke_w", w_flat, {NT{32'd400}});

        // Clear at idx 5 aborts the sweep without a done pulse
        start_and_wait_idx(100, 5, found);
        chk_i("abort_reached_idx5", found, 1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk_v("abort_w", w_flat, '0);
        chk_i("abort_busy", int'(busy), 0);
        dcount = 0;
        for (int c = 0; c < 20; c++) begin
            if (done) dcount++;
            @(negedge clk);
        end
        chk_i("abort_no_done", dcount, 0);
        chk_v("abort_w_stays", w_flat, '0);

        // Start and clear together in IDLE: clear wins, no sweep
        run_sweep(100, 4, 1'b0, -1, bc, dp, da);
        chk_v("pre_sc_w", w_flat, {NT{32'd400}});
        @(negedge clk);
        start = 1'b1;
        clear = 1'b1;
        @(negedge clk);
        start = 1'b0;
        clear = 1'b0;
        chk_v("sc_w", w_flat, '0);
        chk_i("sc_busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        chk_i("sc_busy_later", int'(busy), 0);
        chk_v("sc_w_later", w_flat, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lms_weight_engine.md
Name: lms_weight_engine

Overview:
- Parametrised, time-multiplexed LMS coefficient-update engine for the adaptive FIR.
- One start pulse performs one full sweep: w[k] <= sat(w[k] - leak(w[k]) + ((e*x[k]) >>> mu_shift)) for k = 0..NTAPS-1.
- Uses a single shared multiplier and addresses the reference delay line one tap per cycle.
- Holds the weight array and exports it flat to the FIR datapath.

Parameters:
- NTAPS, 16, number of taps (>=2).
- DW, 14, signed width of error and reference samples.
- WW, 32, signed weight width (WW >= 2*DW+1 required).
- LEAK_SHIFT, 12, leakage term is w >>> LEAK_SHIFT.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  pulse, begins a sweep; honoured only in IDLE.
- e  in  DW  signed error, sampled on start.
- mu_shift  in  5  step size as a right-shift amount, sampled on start.
- leak_en  in  1  leakage enable, sampled on start.
- clear  in  1  synchronous zeroing of weights and abort of any sweep.
- ref_idx  out  $clog2(NTAPS)  tap index requested from the delay line.
- ref_data  in  DW  signed x[ref_idx], combinationally valid in the same cycle.
- busy  out  1  high while a sweep is active.
- done  out  1  one-cycle pulse at sweep completion.
- sat_flag  out  1  sticky, set when any update saturates.
- w_flat  out  NTAPS*WW  weights, tap k at bits [k*WW +: WW].

Behaviour:
- Reset (async, rst=1): all weights 0, FSM IDLE, idx 0, ref_idx 0, busy 0, done 0, sat_flag 0, latched e/mu/leak 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 & clear=0: latch e, mu_shift, leak_en; idx <= 0; go to RUN.
  - clear=1: zero all weights and sat_flag; stay in IDLE; a simultaneous start is dropped.
- RUN, each cycle:
  - ref_idx = idx.
  - prod = e_lat*ref_data (signed, 2*DW bits).
  - delta = prod >>> mu_lat (arithmetic), sign-extended to WW+1.
  - leak = leak_lat ? w[idx] >>> LEAK_SHIFT : 0.
  - sum = w[idx] - leak + delta, computed in WW+1 bits.
  - Saturate sum to [-2^(WW-1), 2^(WW-1)-1]; write it to w[idx]; set sat_flag if clipped.
  - idx == NTAPS-1: go to DONE; else idx++.
- DONE: done=1 for this one cycle only; go to IDLE next cycle.
- busy = (state != IDLE).
- Timing: start accepted at edge T; taps updated at edges T+1..T+NTAPS; done high during the cycle after edge T+NTAPS; a new start is accepted at edge T+NTAPS+2 at the earliest.
- start while busy is ignored; no queueing.
- clear in RUN or DONE: next edge zeroes all weights and sat_flag, goes to IDLE, and done is never asserted for the aborted sweep.
- ref_idx is 0 outside RUN.
- w_flat is registered; each tap changes only on its own write edge.
- mu_shift >= 2*DW gives delta of 0 or -1 (arithmetic shift semantics); this is legal.
- rst mid-sweep: immediate return to the reset values above.

Decomposition:
- Package lms_pkg: FSM state enum (IDLE/RUN/DONE), the saturation helper function, and the localparam IDXW = $clog2(NTAPS).
- Sub-module lms_tap_update: purely combinational datapath (multiply, shift, leak, add, saturate, clip flag), parametrised by DW, WW, LEAK_SHIFT.
- The top module holds the FSM, idx counter, latches and weight array.

Test Plan:
1. Assert rst mid-sweep at idx=7 -> all outputs 0 immediately; w_flat all 0; FSM IDLE.
2. e=100, all x=64, mu_shift=4, leak off, start -> busy for 17 cycles; done pulses once 17 cycles after start; every w=400. Repeat with e=-100 -> every w=0.
3. Arithmetic rounding: e=-3, x[0]=1, mu_shift=1 from zero weights -> w[0]=-2; e=3 -> w[0]=-1.
4. Saturation: e=8191, x[0]=8191, mu_shift=0, repeated sweeps:
   - After 32 sweeps, w[0]=2146959392 and sat_flag=0.
   - 33rd sweep: w[0]=2147483647, sat_flag=1.
   - 34th sweep: w[0] holds at 2147483647.
5. Leakage: preset w[0]=40960 with e=0, leak_en=1 -> w[0]=40950 after one sweep. Same with leak_en=0 -> w[0] stays 40960.
6. Handshake edge cases:
   - start while busy is ignored; done still fires exactly once.
   - clear at idx=5 -> all w=0 next cycle, busy=0, no done pulse.
   - start and clear together in IDLE -> weights cleared and no sweep runs.
